// File: rtl/group_window.sv
// K-row ternary window generator: quantises activations to 2-bit sign codes and
// emits LEN-row columns from LEN-1 line buffers, with zero padding, stride and self-timed flush.
module group_window #(
    parameter int WIDTH_D = 27,
    parameter int SIZE    = 28,
    parameter int CHANNEL = 128,
    parameter int LEN     = 3,
    parameter int PAD     = 1,
    parameter int STRIDE  = 1,
    parameter int GAP     = 0,
    parameter int PADWAIT = 21
) (
    input  logic                      i_sclk,
    input  logic                      i_vsync,
    input  logic                      i_valid,
    input  logic signed [WIDTH_D-1:0] i_tdata,
    output logic                      o_vsync,
    output logic                      o_hsync,
    output logic                      o_valid,
    output logic [2*LEN-1:0]          o_tdata,
    output logic                      o_last,
    output logic                      o_err
);

    localparam int H         = (LEN - 1) / 2;
    localparam int ROWLEN    = SIZE * CHANNEL;
    localparam int NB        = (LEN > 1) ? LEN - 1 : 1;
    localparam int CW        = (ROWLEN > 1) ? $clog2(ROWLEN) : 1;
    localparam int RW        = $clog2(SIZE + H + 1);
    localparam int FIRST_ROW = (PAD != 0) ? H : LEN - 1;
    localparam int NROWS     = (PAD != 0) ? SIZE : SIZE - LEN + 1;
    localparam int NOUT      = (NROWS + STRIDE - 1) / STRIDE;
    localparam int LAST_ROW  = FIRST_ROW + (NOUT - 1) * STRIDE;
    localparam bit HAS_FLUSH = (PAD != 0) && (H > 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [15:0]      r_wcnt;
    logic [1:0]       r_buf [NB][ROWLEN];
    logic [1:0]       r_s1_rd [NB];
    logic [1:0]       r_s1_code;
    logic [LEN-1:0]   r_s1_mask;
    logic             r_s1_valid;
    logic             r_s1_hsync;
    logic             r_s1_last;

    logic             w_accept;
    logic             w_gen;
    logic             w_issue;
    logic             w_col_end;
    logic             w_in_end;
    logic             w_fl_end;
    logic             w_emit;
    logic             w_last;
    logic [1:0]       w_code;
    logic [1:0]       w_wcode;
    logic [LEN-1:0]   w_mask;
    logic [2*LEN-1:0] w_lanes;
    int               w_ord;

    // A flush word is issued like an accepted word carrying code 00, so the buffers keep shifting.
    assign w_accept  = !i_vsync && i_valid && (r_state == S_IDLE || r_state == S_FILL);
    assign w_gen     = !i_vsync && (r_state == S_FLUSH) && (r_wcnt == 16'd0);
    assign w_issue   = w_accept || w_gen;
    assign w_col_end = (r_col == CW'(ROWLEN - 1));
    assign w_in_end  = w_col_end && (r_row == RW'(SIZE - 1));
    assign w_fl_end  = w_col_end && (r_row == RW'(SIZE - 1 + H));
    assign w_code    = (i_tdata == '0) ? 2'b00 : (i_tdata[WIDTH_D-1] ? 2'b11 : 2'b01);
    assign w_wcode   = w_accept ? w_code : 2'b00;

    always_comb begin
        w_ord  = int'(r_row) - FIRST_ROW;
        w_emit = (w_ord >= 0) && (int'(r_row) <= LAST_ROW) &&
                 ((STRIDE == 1) || (w_ord[0] == 1'b0));
        w_last = w_emit && w_col_end && (int'(r_row) == LAST_ROW);
        w_mask = '0;
        // Lane LEN-1-k carries row r-k; rows outside the frame read as zero.
        for (int k = 0; k < LEN; k++) begin
            w_mask[LEN-1-k] = (int'(r_row) < k) || (int'(r_row) > SIZE - 1 + k);
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_wcnt  <= '0;
        end else begin
            if (w_issue) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            case (r_state)
                S_IDLE, S_FILL: begin
                    if (w_accept) begin
                        if (!w_in_end)
                            r_state <= S_FILL;
                        else if (!HAS_FLUSH)
                            r_state <= S_DONE;
                        else if (PADWAIT == 0)
                            r_state <= S_FLUSH;
                        else
                            r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 16'(PADWAIT - 1)) begin
                        r_state <= S_FLUSH;
                        r_wcnt  <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                S_FLUSH: begin
                    if (r_wcnt != 16'd0)
                        r_wcnt <= r_wcnt - 16'd1;
                    else if (w_fl_end)
                        r_state <= S_DONE;
                    else if (w_col_end)
                        r_wcnt <= 16'(GAP);
                end
                default: ;
            endcase
        end
    end

    generate
        if (LEN > 1) begin : g_lines
            always_ff @(posedge i_sclk) begin
                if (w_issue) begin
                    r_buf[0][r_col] <= w_wcode;
                    for (int k = 1; k < LEN - 1; k++) r_buf[k][r_col] <= r_buf[k-1][r_col];
                    for (int k = 0; k < LEN - 1; k++) r_s1_rd[k] <= r_buf[k][r_col];
                end
            end
        end else begin : g_nolines
            always_ff @(posedge i_sclk) r_s1_rd[0] <= 2'b00;
        end
    endgenerate

    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            r_s1_valid <= 1'b0;
            r_s1_hsync <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_code  <= 2'b00;
            r_s1_mask  <= '0;
        end else begin
            r_s1_valid <= w_issue && w_emit;
            r_s1_hsync <= w_issue && w_emit && (r_col == '0);
            r_s1_last  <= w_issue && w_last;
            r_s1_code  <= w_wcode;
            r_s1_mask  <= w_mask;
        end
    end

    always_comb begin
        w_lanes = '0;
        w_lanes[2*(LEN-1) +: 2] = r_s1_mask[LEN-1] ? 2'b00 : r_s1_code;
        for (int k = 1; k < LEN; k++) begin
            w_lanes[2*(LEN-1-k) +: 2] = r_s1_mask[LEN-1-k] ? 2'b00 : r_s1_rd[k-1];
        end
    end

    always_ff @(posedge i_sclk) begin
        o_vsync <= i_vsync;
        if (i_vsync) begin
            o_valid <= 1'b0;
            o_hsync <= 1'b0;
            o_last  <= 1'b0;
            o_tdata <= '0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= r_s1_valid;
            o_hsync <= r_s1_hsync;
            o_last  <= r_s1_last;
            o_tdata <= r_s1_valid ? w_lanes : '0;
            if (i_valid && !w_accept) o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_group_window.sv
// Directed bench for group_window: three small instances (padded, valid-only, stride 2)
// share one input stream; outputs are captured and compared to hand-computed streams.
module tb_group_window;

    localparam int WD = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 vsync;
    logic                 valid;
    logic signed [WD-1:0] tdata;

    logic a_vsync, a_hsync, a_valid, a_last, a_err;
    logic p_vsync, p_hsync, p_valid, p_last, p_err;
    logic s_vsync, s_hsync, s_valid, s_last, s_err;
    logic [5:0] a_tdata, p_tdata, s_tdata;

    group_window #(.WIDTH_D(WD), .SIZE(4), .CHANNEL(2), .LEN(3), .PAD(1), .STRIDE(1),
                   .GAP(0), .PADWAIT(21)) dut_a (
        .i_sclk(clk), .i_vsync(vsync), .i_valid(valid), .i_tdata(tdata),
        .o_vsync(a_vsync), .o_hsync(a_hsync), .o_valid(a_valid), .o_tdata(a_tdata),
        .o_last(a_last), .o_err(a_err));

    group_window #(.WIDTH_D(WD), .SIZE(4), .CHANNEL(2), .LEN(3), .PAD(0), .STRIDE(1),
                   .GAP(0), .PADWAIT(21)) dut_p (
        .i_sclk(clk), .i_vsync(vsync), .i_valid(valid), .i_tdata(tdata),
        .o_vsync(p_vsync), .o_hsync(p_hsync), .o_valid(p_valid), .o_tdata(p_tdata),
        .o_last(p_last), .o_err(p_err));

    group_window #(.WIDTH_D(WD), .SIZE(4), .CHANNEL(2), .LEN(3), .PAD(1), .STRIDE(2),
                   .GAP(0), .PADWAIT(21)) dut_s (
        .i_sclk(clk), .i_vsync(vsync), .i_valid(valid), .i_tdata(tdata),
        .o_vsync(s_vsync), .o_hsync(s_hsync), .o_valid(s_valid), .o_tdata(s_tdata),
        .o_last(s_last), .o_err(s_err));

    typedef struct {
        logic [5:0] d;
        logic       h;
        logic       l;
        int         t;
    } cap_t;

    typedef struct {
        logic signed [WD-1:0] x;
        logic [1:0]           code;
    } sign_vec_t;

    cap_t      cap_a[$];
    cap_t      cap_p[$];
    cap_t      cap_s[$];
    sign_vec_t sign_tab[5];
    int        cyc        = 0;
    int        last_a_cnt = 0;
    int        checks     = 0;
    int        errors     = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_valid) begin
            cap_a.push_back('{a_tdata, a_hsync, a_last, cyc});
            if (a_last) last_a_cnt++;
        end
        if (p_valid) cap_p.push_back('{p_tdata, p_hsync, p_last, cyc});
        if (s_valid) cap_s.push_back('{s_tdata, s_hsync, s_last, cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        vsync = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        cap_a.delete();
        cap_p.delete();
        cap_s.delete();
        last_a_cnt = 0;
        @(negedge clk);
    endtask

    // Row r carries value r+1 in every word; first word coincides with reset release.
    task automatic send_frame1();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                vsync = 1'b0;
                valid = 1'b1;
                tdata = WD'(r + 1);
                @(negedge clk);
            end
        end
        valid = 1'b0;
        tdata = '0;
    endtask

    task automatic wait_last(input string tag);
        int n = 0;
        while (last_a_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(last_a_cnt), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame1(input string tag);
        logic [5:0] exp_center[4];
        logic [5:0] exp_q[$];
        exp_center = '{6'h14, 6'h15, 6'h15, 6'h05};
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 8; w++) exp_q.push_back(exp_center[c]);
        chk({tag, "_a_cnt"}, 32'(cap_a.size()), 32'd32);
        for (int i = 0; i < cap_a.size() && i < 32; i++) begin
            chk($sformatf("%s_a_d%0d", tag, i), 32'(cap_a[i].d), 32'(exp_q.pop_front()));
            chk($sformatf("%s_a_h%0d", tag, i), 32'(cap_a[i].h), 32'(i % 8 == 0));
            chk($sformatf("%s_a_l%0d", tag, i), 32'(cap_a[i].l), 32'(i == 31));
        end
        if (cap_a.size() > 24)
            chk({tag, "_a_flush_gap"}, 32'(cap_a[24].t - cap_a[23].t), 32'd22);
        chk({tag, "_p_cnt"}, 32'(cap_p.size()), 32'd16);
        for (int i = 0; i < cap_p.size() && i < 16; i++) begin
            chk($sformatf("%s_p_d%0d", tag, i), 32'(cap_p[i].d), 32'h15);
            chk($sformatf("%s_p_h%0d", tag, i), 32'(cap_p[i].h), 32'(i % 8 == 0));
            chk($sformatf("%s_p_l%0d", tag, i), 32'(cap_p[i].l), 32'(i == 15));
        end
        chk({tag, "_s_cnt"}, 32'(cap_s.size()), 32'd16);
        for (int i = 0; i < cap_s.size() && i < 16; i++) begin
            chk($sformatf("%s_s_d%0d", tag, i), 32'(cap_s[i].d), (i < 8) ? 32'h14 : 32'h15);
            chk($sformatf("%s_s_h%0d", tag, i), 32'(cap_s[i].h), 32'(i % 8 == 0));
            chk($sformatf("%s_s_l%0d", tag, i), 32'(cap_s[i].l), 32'(i == 15));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sign_tab[0] = '{WD'(1), 2'b01};
        sign_tab[1] = '{WD'(0), 2'b00};
        sign_tab[2] = '{-WD'(1), 2'b11};
        sign_tab[3] = '{27'sh4000000, 2'b11};
        sign_tab[4] = '{27'sh3ffffff, 2'b01};

        vsync = 1'b1;
        valid = 1'b0;
        tdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vsync", 32'(a_vsync), 32'd1);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_hsync", 32'(a_hsync), 32'd0);
        chk("rst_last", 32'(a_last), 32'd0);
        chk("rst_tdata", 32'(a_tdata), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);

        // Basic padded frame plus valid-only and stride-2 views of the same input.
        do_reset();
        send_frame1();
        wait_last("f1");
        chk("f1_err", 32'(a_err), 32'd0);
        check_frame1("f1");

        // Sign encoding on row 1, one word at a time to expose the two-cycle latency.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            vsync = 1'b0;
            valid = 1'b1;
            tdata = WD'(5);
            @(negedge clk);
        end
        valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            tdata = sign_tab[i].x;
            @(negedge clk);
            valid = 1'b0;
            chk($sformatf("sgn_early%0d", i), 32'(a_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("sgn_valid%0d", i), 32'(a_valid), 32'd1);
            chk($sformatf("sgn_code%0d", i), 32'(a_tdata[5:4]), 32'(sign_tab[i].code));
            chk($sformatf("sgn_old%0d", i), 32'(a_tdata[3:0]), 32'h4);
            chk($sformatf("sgn_hs%0d", i), 32'(a_hsync), 32'(i == 0));
        end

        // Abort in the middle of the flush row, then a clean frame must match exactly.
        do_reset();
        send_frame1();
        repeat (24) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        chk("abort_valid", 32'(a_valid), 32'd0);
        chk("abort_last", 32'(a_last), 32'd0);
        chk("abort_vsync", 32'(a_vsync), 32'd1);
        chk("abort_nolast", 32'(last_a_cnt), 32'd0);
        chk("abort_in_flush", 32'(cap_a.size() >= 24 && cap_a.size() < 32), 32'd1);
        do_reset();
        send_frame1();
        wait_last("rf");
        check_frame1("rf");

        // Word arriving during the pad wait is dropped and flagged; stream unchanged.
        do_reset();
        send_frame1();
        repeat (5) @(negedge clk);
        valid = 1'b1;
        tdata = -WD'(1);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("drop_err_set", 32'(a_err), 32'd1);
        wait_last("dw");
        check_frame1("dw");
        chk("drop_err_held", 32'(a_err), 32'd1);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_no_output", 32'(cap_a.size()), 32'd32);
        chk("done_err", 32'(a_err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(a_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
